// File: rtl/fifo_uart_tx.sv
// Serial drain stage for the FIFO core: pops one word per frame and shifts it out
// as start bit, WIDTH data bits LSB first, stop bit, on an idle-high line.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             empty,
  input  logic [WIDTH-1:0] fifo_output_data,
  output logic             rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [2:0]       state_dbg
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t           state;
  logic [BW-1:0]    baud;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nx;
  logic             baud_end;

  // Handshake: rd_en is a one-cycle pop strobe to the core; the popped word is
  // presented on fifo_output_data in the following cycle and captured in WAIT.
  // Gating with reset keeps the strobe low while the block is held in reset.
  assign rd_en     = reset && (state == S_IDLE) && en && !empty;
  assign busy      = (state != S_IDLE) || rd_en;
  assign baud_end  = (baud == BAUD_LAST);
  assign tx_done   = (state == S_STOP) && baud_end;
  assign shift_nx  = shift >> 1;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx   <= 1'b1;
          baud <= '0;
          if (rd_en) state <= S_WAIT;
        end
        S_WAIT: begin
          shift <= fifo_output_data;
          tx    <= 1'b0;
          baud  <= '0;
          state <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            state   <= S_DATA;
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              // Next bit is driven from the shifted value so tx stays registered.
              shift   <= shift_nx;
              tx      <= shift_nx[0];
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (baud_end) begin
            state <= S_IDLE;
            baud  <= '0;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          baud  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT and a cycle
// sampled serial receiver decodes every frame against the expected-word queue.
module tb_fifo_uart_tx;

  localparam int W     = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (W + 2) * CPB;

  logic         clk;
  logic         reset;
  logic         en;
  logic         empty;
  logic [W-1:0] fifo_output_data;
  logic         rd_en;
  logic         tx;
  logic         busy;
  logic         tx_done;
  logic [2:0]   state_dbg;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .reset            (reset),
    .en               (en),
    .empty            (empty),
    .fifo_output_data (fifo_output_data),
    .rd_en            (rd_en),
    .tx               (tx),
    .busy             (busy),
    .tx_done          (tx_done),
    .state_dbg        (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model state
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           pop_cyc[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           pops = 0;
  int           starts = 0;
  int           frames = 0;
  int           last_pop = 0;
  int           last_done = 0;
  int           last_gap = 0;
  int           mcnt = 0;
  int           slot;
  int           push_cyc;
  logic         active = 1'b0;
  logic         frame_open = 1'b0;
  logic         pop;
  logic         exp_bit;
  logic [W-1:0] cur_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task push(input logic [W-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    empty = 1'b0;
  endtask

  // Serial receiver and protocol checks, evaluated once per cycle at the negedge.
  task monitor;
    cyc++;
    if (!reset) begin
      chk("rst_tx", tx, 1);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_done", tx_done, 0);
      chk("rst_state", state_dbg, 0);
      if (frame_open && exp_q.size() > 0) void'(exp_q.pop_front());
      frame_open = 1'b0;
      active     = 1'b0;
    end else begin
      chk("busy", busy, rd_en | frame_open);
      if (rd_en) begin
        chk("pop_when_empty", empty, 0);
        pops++;
        pop_cyc.push_back(cyc);
        last_pop   = cyc;
        frame_open = 1'b1;
      end
      if (active) mcnt++;
      else if (!tx) begin
        active = 1'b1;
        mcnt   = 0;
        starts++;
        chk("pop_to_start", cyc - last_pop, 2);
        if (last_done != 0) last_gap = cyc - last_done;
        chk("exp_avail", exp_q.size() > 0, 1);
        cur_exp = (exp_q.size() > 0) ? exp_q[0] : '0;
      end
      if (active) begin
        slot    = mcnt / CPB;
        exp_bit = (slot == 0) ? 1'b0 : (slot <= W) ? cur_exp[slot-1] : 1'b1;
        chk("tx_bit", tx, exp_bit);
        chk("tx_done", tx_done, mcnt == FRAME - 1);
        if (mcnt == FRAME - 1) begin
          active     = 1'b0;
          frame_open = 1'b0;
          frames++;
          last_done  = cyc;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_tx_done", tx_done, 0);
      end
    end
  endtask

  // driver: one clock cycle, with the FIFO model reacting to the pop at the edge
  task tick;
    @(negedge clk);
    pop = rd_en;
    monitor();
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) fifo_output_data = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
  endtask

  task wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames < n && k < budget) begin
      tick();
      k++;
    end
    chk("frames_reached", frames, n);
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b1;
    empty = 1'b1;
    fifo_output_data = '0;

    // reset held with data pending and enable high
    push(8'hA5);
    repeat (5) tick();
    reset = 1'b1;

    // single frame timing
    wait_frames(1, 100);
    chk("pop_count_1", pops, 1);
    chk("done_latency", last_done - pop_cyc[0], 41);
    repeat (3) tick();

    // back-to-back frames
    push(8'h00);
    push(8'hFF);
    wait_frames(3, 200);
    chk("pop_count_3", pops, 3);
    chk("pop_spacing", pop_cyc[2] - pop_cyc[1], 42);
    chk("idle_gap", last_gap, 3);
    repeat (20) tick();
    chk("no_pop_when_drained", pops, 3);

    // empty gating
    repeat (100) tick();
    chk("gated_pops", pops, 3);
    chk("gated_starts", starts, 3);
    push_cyc = cyc;
    push(8'h5A);
    tick();
    chk("pop_same_cycle", last_pop, push_cyc + 1);
    wait_frames(4, 100);

    // enable dropped mid-frame, FIFO output disturbed during the frame
    push(8'h3C);
    repeat (12) tick();
    chk("in_data", (mcnt >= CPB) && (mcnt < CPB * (W + 1)), 1);
    fifo_output_data = W'($urandom_range(0, 255));
    push(8'h77);
    en = 1'b0;
    wait_frames(5, 100);
    repeat (60) tick();
    chk("no_pop_after_en_drop", pops, 5);
    chk("word_still_queued", exp_q.size(), 1);

    // reset during bit 3 of DATA
    en = 1'b1;
    for (int i = 0; i < 60 && !(active && mcnt == 17); i++) tick();
    chk("reached_bit3", mcnt, 17);
    reset = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    push(8'(8'hC0 | $urandom_range(0, 15)));
    repeat (3) tick();
    reset = 1'b1;
    wait_frames(6, 100);
    chk("pop_count_final", pops, 7);
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
